// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction sequencer: FSM state encoding,
// quarter-phase constants within one SCL bit, and the byte bit count.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_STOP
  } state_t;

  // Quarter phases of one SCL bit period
  localparam logic [1:0] PH_Q0 = 2'd0;  // SCL low, SDA may change
  localparam logic [1:0] PH_Q1 = 2'd1;  // SCL released (rising)
  localparam logic [1:0] PH_Q2 = 2'd2;  // SCL high, SDA sampled at end
  localparam logic [1:0] PH_Q3 = 2'd3;  // SCL pulled low (falling)

  localparam int unsigned BIT_COUNT = 8;
  localparam logic [2:0]  LAST_BIT  = 3'(BIT_COUNT - 1);

  // Bit of a byte transmitted MSB first, idx counts bits already sent
  function automatic logic msb_bit(input logic [7:0] b, input logic [2:0] idx);
    return b[3'd7 - idx];
  endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-bit tick generator for the I2C sequencer. Produces a one-cycle
// tick every CLK_DIV clocks and the 2-bit phase of the current quarter.
// With I2C_SEQ_CLK_STRETCH_EN defined, the counter freezes in Q1 while the
// sampled SCL line is still low (slave clock stretching).
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       scl_i,
  output logic       tick,
  output logic [1:0] phase
);

  logic [15:0] cnt;
  logic        hold;

`ifdef I2C_SEQ_CLK_STRETCH_EN
  assign hold = run && (phase == PH_Q1) && !scl_i;
`else
  logic stretch_unused;
  assign stretch_unused = scl_i;
  assign hold = 1'b0;
`endif

  assign tick = run && !hold && (cnt == 16'(CLK_DIV - 1));

  // Divider counter and quarter-phase register; parked at zero when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= PH_Q0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= PH_Q0;
    end else if (!hold) begin
      if (tick) begin
        cnt   <= '0;
        phase <= phase + 2'd1;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Two-requester I2C master: round-robin arbitration, then one single-byte
// write or read transaction (START, address, ACK, data, ACK/NACK, STOP).
// Optional macro I2C_SEQ_CLK_STRETCH_EN enables slave clock stretching.
module i2c_txn_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [13:0] req_addr,
  input  logic [1:0]  req_rw,
  input  logic [15:0] req_wdata,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic        nack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        scl_o,
  input  logic        scl_i,
  output logic        sda_oe,
  input  logic        sda_i
);

  state_t     state, state_next;
  logic       tick;
  logic [1:0] phase;
  logic       timer_run;
  logic       bit_end, sample_pt, last_bit, bit_scl;
  logic [2:0] bit_cnt;
  logic [7:0] addr_byte, wdata_byte, rx_shift;
  logic       rw;
  logic       last_served;
  logic       sel;

  assign timer_run = (state != ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign bit_end   = tick && (phase == PH_Q3);
  assign sample_pt = tick && (phase == PH_Q2);
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign bit_scl   = (phase == PH_Q1) || (phase == PH_Q2);

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .run   (timer_run),
    .scl_i (scl_i),
    .tick  (tick),
    .phase (phase)
  );

  // Round-robin pick: with both requesting, favour the one not served last
  always_comb begin
    if (req_valid == 2'b11) sel = ~last_served;
    else                    sel = req_valid[1];
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; every bus state advances at the end of a bit (Q3 tick)
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (req_valid != '0)       state_next = ST_START;
      ST_START:    if (bit_end)               state_next = ST_ADDR;
      ST_ADDR:     if (bit_end && last_bit)   state_next = ST_ADDR_ACK;
      ST_ADDR_ACK: if (bit_end)               state_next = nack ? ST_STOP : ST_DATA;
      ST_DATA:     if (bit_end && last_bit)   state_next = ST_DATA_ACK;
      ST_DATA_ACK: if (bit_end)               state_next = ST_STOP;
      ST_STOP:     if (bit_end)               state_next = ST_IDLE;
      default:                                state_next = ST_IDLE;
    endcase
  end

  // Bus line drive decoded from state and quarter phase
  always_comb begin
    scl_o  = 1'b1;
    sda_oe = 1'b0;
    unique case (state)
      ST_START: begin
        scl_o  = (phase != PH_Q3);
        sda_oe = (phase != PH_Q0);
      end
      ST_ADDR: begin
        scl_o  = bit_scl;
        sda_oe = ~msb_bit(addr_byte, bit_cnt);
      end
      ST_DATA: begin
        scl_o  = bit_scl;
        sda_oe = !rw && ~msb_bit(wdata_byte, bit_cnt);
      end
      ST_ADDR_ACK, ST_DATA_ACK: begin
        scl_o  = bit_scl;
      end
      ST_STOP: begin
        scl_o  = (phase != PH_Q0);
        sda_oe = (phase != PH_Q3);
      end
      default: begin
        scl_o  = 1'b1;
        sda_oe = 1'b0;
      end
    endcase
  end

  // Transaction latch, bit counter, ACK/read sampling and completion handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant       <= '0;
      done        <= '0;
      nack        <= 1'b0;
      rdata       <= '0;
      bit_cnt     <= '0;
      addr_byte   <= '0;
      wdata_byte  <= '0;
      rx_shift    <= '0;
      rw          <= 1'b0;
      last_served <= 1'b1;
    end else begin
      done <= '0;

      if (state == ST_IDLE && state_next == ST_START) begin
        grant      <= sel ? 2'b10 : 2'b01;
        addr_byte  <= {(sel ? req_addr[13:7] : req_addr[6:0]), req_rw[sel]};
        wdata_byte <= sel ? req_wdata[15:8] : req_wdata[7:0];
        rw         <= req_rw[sel];
        nack       <= 1'b0;
        bit_cnt    <= '0;
      end

      if (bit_end && (state == ST_ADDR || state == ST_DATA))
        bit_cnt <= last_bit ? '0 : bit_cnt + 3'd1;

      if (sample_pt) begin
        if (state == ST_ADDR_ACK || (state == ST_DATA_ACK && !rw))
          nack <= sda_i;
        if (state == ST_DATA && rw) begin
          rx_shift <= {rx_shift[6:0], sda_i};
          if (last_bit) rdata <= {rx_shift[6:0], sda_i};
        end
      end

      if (state == ST_STOP && bit_end) begin
        done        <= grant;
        grant       <= '0;
        last_served <= grant[1];
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a small I2C slave/bus monitor.
module tb_i2c_txn_sequencer;

  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [13:0] req_addr;
  logic [1:0]  req_rw;
  logic [15:0] req_wdata;
  logic [1:0]  grant, done;
  logic        nack, busy, scl_o, scl_i, sda_oe, sda_i;
  logic [7:0]  rdata;

  logic        stretch_low = 1'b0;
  logic        slave_pull  = 1'b0;
  logic        slave_present = 1'b0;
  logic [6:0]  slave_addr = '0;
  logic [7:0]  slave_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  // bus monitor state
  logic scl_prev = 1'b1;
  logic sda_prev = 1'b1;
  logic addr_ack = 1'b0;
  logic bitlog [64];
  int   nbits = 0;
  int   start_cnt = 0;
  int   stop_cnt = 0;

  assign scl_i = scl_o & ~stretch_low;
  assign sda_i = ~(sda_oe | slave_pull);

  always #5 clk = ~clk;

  i2c_txn_sequencer #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .req_wdata (req_wdata),
    .grant     (grant),
    .done      (done),
    .nack      (nack),
    .rdata     (rdata),
    .busy      (busy),
    .scl_o     (scl_o),
    .scl_i     (scl_i),
    .sda_oe    (sda_oe),
    .sda_i     (sda_i)
  );

  function automatic logic [7:0] get_byte(input int base);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b = {b[6:0], bitlog[base + i]};
    return b;
  endfunction

  // Bus monitor and slave: log SDA at SCL rises, drive ACK / read data on SCL falls
  always @(negedge clk) begin
    if (scl_prev && scl_o && sda_prev && !sda_i) begin
      start_cnt++;
      nbits = 0;
      addr_ack = 1'b0;
      slave_pull = 1'b0;
    end else if (scl_prev && scl_o && !sda_prev && sda_i) begin
      stop_cnt++;
    end
    if (!scl_prev && scl_o) begin
      if (nbits < 64) bitlog[nbits] = sda_i;
      nbits++;
    end
    if (scl_prev && !scl_o) begin
      slave_pull = 1'b0;
      if (nbits == 8) begin
        addr_ack = slave_present && (get_byte(0) >> 1) == {1'b0, slave_addr};
        slave_pull = addr_ack;
      end else if (addr_ack && bitlog[7] && nbits >= 9 && nbits <= 16) begin
        slave_pull = ~slave_rdata[16 - nbits];
      end else if (addr_ack && !bitlog[7] && nbits == 17) begin
        slave_pull = 1'b1;
      end
    end
    scl_prev = scl_o;
    sda_prev = sda_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed timeout expected event within %0d cycles", tag, LIMIT);
  endtask

  // Request with mask, wait grant then done; returns grant and grant-to-done cycles
  task automatic do_txn(input logic [1:0] mask, input logic keep,
                        output logic [1:0] g, output int dur);
    int t;
    g = '0;
    dur = -1;
    req_valid = mask;
    t = 0;
    while (grant == '0 && t < LIMIT) begin @(negedge clk); t++; end
    if (grant == '0) begin
      timeout("grant_wait");
    end else begin
      g = grant;
      chk("busy_on_grant", busy, 1'b1);
      chk("nack_clr_on_grant", nack, 1'b0);
      t = 0;
      while (done == '0 && t < LIMIT) begin @(negedge clk); t++; end
      if (done == '0) begin
        timeout("done_wait");
      end else begin
        dur = t;
        chk("done_to_owner", done, g);
        chk("grant_clr_at_done", grant, 2'b00);
        chk("busy_clr_at_done", busy, 1'b0);
      end
    end
    if (!keep) req_valid = '0;
    @(negedge clk);
    chk("done_one_cycle", done, 2'b00);
  endtask

  initial begin
    logic [1:0] g;
    int dur, st0, sp0, t;

    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_rw = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_scl_o", scl_o, 1'b1);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_nack", nack, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_no_grant", grant, 2'b00);

    // req0 write 0x50 <- 0xA5, slave ACKs
    slave_present = 1'b1;
    slave_addr = 7'h50;
    req_addr[6:0] = 7'h50;
    req_rw = 2'b00;
    req_wdata[7:0] = 8'hA5;
    st0 = start_cnt; sp0 = stop_cnt;
    do_txn(2'b01, 1'b0, g, dur);
    chk("wr_grant", g, 2'b01);
    chk("wr_duration", dur, 320);
    chk("wr_nack", nack, 1'b0);
    chk("wr_start_seen", start_cnt - st0, 1);
    chk("wr_stop_seen", stop_cnt - sp0, 1);
    chk("wr_scl_rises", nbits, 19);
    chk("wr_addr_byte", get_byte(0), 8'hA0);
    chk("wr_addr_ack", bitlog[8], 1'b0);
    chk("wr_data_byte", get_byte(9), 8'hA5);
    chk("wr_data_ack", bitlog[17], 1'b0);
    chk("wr_rdata_kept", rdata, 8'h00);

    // req1 read 0x3C, slave returns 0x96
    slave_addr = 7'h3C;
    slave_rdata = 8'h96;
    req_addr[13:7] = 7'h3C;
    req_rw = 2'b10;
    do_txn(2'b10, 1'b0, g, dur);
    chk("rd_grant", g, 2'b10);
    chk("rd_duration", dur, 320);
    chk("rd_nack", nack, 1'b0);
    chk("rd_rdata", rdata, 8'h96);
    chk("rd_addr_byte", get_byte(0), 8'h79);
    chk("rd_addr_ack", bitlog[8], 1'b0);
    chk("rd_bus_byte", get_byte(9), 8'h96);
    chk("rd_master_nack", bitlog[17], 1'b1);

    // No slave at 0x11: address NACK, straight to STOP
    slave_present = 1'b0;
    req_addr[6:0] = 7'h11;
    req_rw = 2'b00;
    req_wdata[7:0] = 8'h5A;
    sp0 = stop_cnt;
    do_txn(2'b01, 1'b0, g, dur);
    chk("na_nack", nack, 1'b1);
    chk("na_duration", dur, 176);
    chk("na_scl_rises", nbits, 10);
    chk("na_addr_byte", get_byte(0), 8'h22);
    chk("na_ack_bit", bitlog[8], 1'b1);
    chk("na_stop_seen", stop_cnt - sp0, 1);
    repeat (10) @(negedge clk);
    chk("na_nack_hold", nack, 1'b1);
    chk("na_rdata_hold", rdata, 8'h96);

    // Reset during DATA bit 3 of a write
    slave_present = 1'b1;
    slave_addr = 7'h50;
    req_addr[6:0] = 7'h50;
    req_wdata[7:0] = 8'hA5;
    req_valid = 2'b01;
    t = 0;
    while (!(busy && nbits == 13) && t < LIMIT) begin @(negedge clk); t++; end
    if (!(busy && nbits == 13)) timeout("rst_point_wait");
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    chk("midrst_scl_o", scl_o, 1'b1);
    chk("midrst_sda_oe", sda_oe, 1'b0);
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_txn(2'b01, 1'b0, g, dur);
    chk("postrst_grant", g, 2'b01);
    chk("postrst_duration", dur, 320);
    chk("postrst_nack", nack, 1'b0);
    chk("postrst_data_byte", get_byte(9), 8'hA5);

    // Round robin with both requesting after reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req_addr = {7'h50, 7'h50};
    req_rw = 2'b00;
    req_wdata = {8'h3C, 8'hA5};
    do_txn(2'b11, 1'b1, g, dur);
    chk("rr_grant_1st", g, 2'b01);
    chk("rr_data_1st", get_byte(9), 8'hA5);
    do_txn(2'b11, 1'b1, g, dur);
    chk("rr_grant_2nd", g, 2'b10);
    chk("rr_data_2nd", get_byte(9), 8'h3C);
    do_txn(2'b11, 1'b0, g, dur);
    chk("rr_grant_3rd", g, 2'b01);
    chk("rr_duration_3rd", dur, 320);

`ifdef I2C_SEQ_CLK_STRETCH_EN
    // Slave holds SCL low for 20 clk in the first address bit's Q1
    repeat (3) @(negedge clk);
    req_valid = 2'b01;
    t = 0;
    while (grant == '0 && t < LIMIT) begin @(negedge clk); t++; end
    if (grant == '0) timeout("st_grant_wait");
    t = 0;
    while (!(busy && nbits == 1) && t < LIMIT) begin @(negedge clk); t++; end
    if (!(busy && nbits == 1)) timeout("st_q1_wait");
    stretch_low = 1'b1;
    repeat (20) @(negedge clk);
    stretch_low = 1'b0;
    t = 0;
    while (done == '0 && t < LIMIT) begin @(negedge clk); t++; end
    if (done == '0) timeout("st_done_wait");
    req_valid = '0;
    chk("st_done", done, 2'b01);
    chk("st_nack", nack, 1'b0);
    chk("st_data_byte", get_byte(9), 8'hA5);
    chk("st_addr_byte", get_byte(0), 8'hA0);
    repeat (3) @(negedge clk);
    do_txn(2'b01, 1'b0, g, dur);
    chk("st_baseline", dur, 320);
    req_valid = 2'b01;
    t = 0;
    while (grant == '0 && t < LIMIT) begin @(negedge clk); t++; end
    if (grant == '0) timeout("st2_grant_wait");
    dur = 0;
    while (!(busy && nbits == 1) && dur < LIMIT) begin @(negedge clk); dur++; end
    stretch_low = 1'b1;
    repeat (20) @(negedge clk);
    stretch_low = 1'b0;
    dur += 20;
    while (done == '0 && dur < LIMIT) begin @(negedge clk); dur++; end
    req_valid = '0;
    chk("st_duration", dur, 340);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
